pix_frame_streamer: RTL and testbench

Downstream stage of the display circuit's `main` block. It captures each full `pix` frame (WIDTH*HEIGHT bits) through a valid/ready handshake and serializes it into OUT_W-bit words in row-major order for the display link. Row and frame markers travel with each word. A ping-pong shadow register lets the next frame be accepted while the current one streams, so back-to-back frames leave no idle cycle between them.

---
 rtl/pix_frame_streamer.sv | 135 +++++++++++++
 tb/tb_pix_frame_streamer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pix_frame_streamer.sv
// Captures whole pix frames via valid/ready and streams them as OUT_W-bit words in
// row-major order with row/frame markers; a shadow frame buffer hides the frame turnaround.
module pix_frame_streamer #(
  parameter int WIDTH  = 120,
  parameter int HEIGHT = 52,
  parameter int OUT_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH*HEIGHT-1:0] in_pix,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sol,
  output logic                    out_eol,
  output logic                    out_eof,
  output logic [CNT_W-1:0]        frame_cnt
);
  localparam int NPIX   = WIDTH * HEIGHT;
  localparam int WPR    = WIDTH / OUT_W;
  localparam int WPF    = WPR * HEIGHT;
  localparam int WIDX_W = (WPF > 1) ? $clog2(WPF) : 1;
  localparam int COL_W  = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(WPF - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WPR - 1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              shadow_full_q, shadow_full_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [NPIX-1:0]   active_q, active_d;
  logic [NPIX-1:0]   shadow_q, shadow_d;

  logic in_acc, out_acc, last_word;

  // in_ready must not look at in_valid, so it is built from state only
  assign in_ready  = (state_q == S_IDLE) || !shadow_full_q;
  assign out_valid = (state_q == S_STREAM);
  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid && out_ready;
  assign last_word = (widx_q == WIDX_LAST);

  assign out_data  = out_valid ? active_q[widx_q*OUT_W +: OUT_W] : '0;
  assign out_sol   = out_valid && (col_q == '0);
  assign out_eol   = out_valid && (col_q == COL_LAST);
  assign out_eof   = out_valid && last_word;
  assign frame_cnt = frame_cnt_q;

  always_comb begin
    state_d       = state_q;
    shadow_full_d = shadow_full_q;
    widx_d        = widx_q;
    col_d         = col_q;
    row_d         = row_q;
    frame_cnt_d   = frame_cnt_q;
    active_d      = active_q;
    shadow_d      = shadow_q;
    case (state_q)
      S_IDLE: begin
        if (in_acc) begin
          active_d = in_pix;
          widx_d   = '0;
          col_d    = '0;
          row_d    = '0;
          state_d  = S_STREAM;
        end
      end
      default: begin
        if (out_acc && last_word) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
          widx_d      = '0;
          col_d       = '0;
          row_d       = '0;
          // shadow has priority; in_ready is low then, so no input can collide
          if (shadow_full_q) begin
            active_d      = shadow_q;
            shadow_full_d = 1'b0;
          end else if (in_acc) begin
            active_d = in_pix;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          if (out_acc) begin
            widx_d = widx_q + 1'b1;
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
          if (in_acc) begin
            shadow_d      = in_pix;
            shadow_full_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      shadow_full_q <= 1'b0;
      widx_q        <= '0;
      col_q         <= '0;
      row_q         <= '0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      shadow_full_q <= shadow_full_d;
      widx_q        <= widx_d;
      col_q         <= col_d;
      row_q         <= row_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  // Frame buffers need no reset: the cleared state/flag makes their contents dead.
  always_ff @(posedge clk) begin
    active_q <= active_d;
    shadow_q <= shadow_d;
  end
endmodule

// File: tb/tb_pix_frame_streamer.sv
// Bench for pix_frame_streamer: vector table, directed corner sequences and random
// traffic, all checked every cycle against a frame-queue reference model.
module tb_pix_frame_streamer;
  localparam int WIDTH  = 120;
  localparam int HEIGHT = 52;
  localparam int OW     = 8;
  localparam int CW     = 2;
  localparam int N      = WIDTH * HEIGHT;
  localparam int WPR    = WIDTH / OW;
  localparam int WPF    = WPR * HEIGHT;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, out_ready;
  logic [N-1:0]  in_pix;
  logic          in_ready, out_valid, out_sol, out_eol, out_eof;
  logic [OW-1:0] out_data;
  logic [CW-1:0] frame_cnt;

  pix_frame_streamer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .OUT_W(OW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_pix(in_pix), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sol(out_sol), .out_eol(out_eol), .out_eof(out_eof), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: queue of held frames (head = streaming), word position, frame count.
  logic [N-1:0] fq[$];
  int  pos = 0, mcnt = 0, eof_seen = 0;
  bit  snap_ev, snap_er, acc_in_last, chk_en = 1'b0;
  int  total = 0, bad = 0;
  int  wcnt = 0, nz_cnt = 0, nz_idx = -1;
  logic [OW-1:0] nz_val;
  logic [N-1:0]  junk;

  typedef struct {
    bit rn, iv, ordy; int pat;
    bit ev, er; logic [7:0] ed; bit es, ee, ef;
  } vec_t;
  vec_t vt[6];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] pat_frame(input int p);
    logic [N-1:0] f;
    f = '0;
    case (p)
      1: for (int i = 0; i < N; i++) f[i] = i[0];
      2: f = '1;
      3: f[3*WIDTH + 9] = 1'b1;
      default: ;
    endcase
    return f;
  endfunction

  function automatic logic [N-1:0] rnd_frame();
    logic [N-1:0] f;
    for (int i = 0; i < N; i += 32) f[i +: 32] = $urandom;
    return f;
  endfunction

  task automatic check_outs();
    logic [N-1:0] f;
    logic [OW-1:0] ed;
    bit ev, er, es, ee, ef;
    ev = fq.size() > 0; er = fq.size() < 2;
    ed = '0; es = 0; ee = 0; ef = 0;
    if (ev) begin
      f  = fq[0];
      ed = f[pos*OW +: OW];
      es = (pos % WPR) == 0;
      ee = (pos % WPR) == WPR - 1;
      ef = pos == WPF - 1;
    end
    cmp("out_valid", 32'(out_valid), 32'(ev));
    cmp("in_ready",  32'(in_ready),  32'(er));
    cmp("out_data",  32'(out_data),  32'(ed));
    cmp("out_sol",   32'(out_sol),   32'(es));
    cmp("out_eol",   32'(out_eol),   32'(ee));
    cmp("out_eof",   32'(out_eof),   32'(ef));
    cmp("frame_cnt", 32'(frame_cnt), 32'(mcnt));
  endtask

  task automatic pre(input bit rn, input bit iv, input logic [N-1:0] pix, input bit ordy);
    rst_n = rn; in_valid = iv; in_pix = pix; out_ready = ordy;
    @(negedge clk);
    if (chk_en) check_outs();
    snap_ev = fq.size() > 0; snap_er = fq.size() < 2;
    if (out_valid === 1'b1 && out_ready) begin
      if (out_data != '0) begin nz_cnt++; nz_idx = wcnt; nz_val = out_data; end
      wcnt = (out_eof === 1'b1) ? 0 : wcnt + 1;
    end
  endtask

  task automatic post();
    @(posedge clk); #1;
    acc_in_last = 1'b0;
    if (!rst_n) begin
      fq.delete(); pos = 0; mcnt = 0;
    end else begin
      if (snap_ev && out_ready) begin
        pos++;
        if (pos == WPF) begin
          void'(fq.pop_front()); pos = 0; mcnt = (mcnt + 1) % (1 << CW); eof_seen++;
        end
      end
      if (in_valid && snap_er) begin fq.push_back(in_pix); acc_in_last = 1'b1; end
    end
  endtask

  task automatic step(input bit rn, input bit iv, input logic [N-1:0] pix, input bit ordy);
    pre(rn, iv, pix, ordy);
    post();
  endtask

  task automatic drain(input bit rnd_rdy, output int n);
    n = 0;
    while (fq.size() > 0 && n < 5000) begin
      step(1'b1, 1'b0, junk, rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      n++;
    end
    total++;
    if (fq.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d frames left after %0d cycles", fq.size(), n);
    end
  endtask

  initial begin
    int n, k, pushed, e0;
    bit pend;
    logic [N-1:0] cur;
    int exp_wrap[5];
    exp_wrap = '{1, 2, 3, 0, 1};
    junk = rnd_frame();
    //           rn iv rdy pat  ev er data   sol eol eof
    vt[0] = '{1, 0, 1, 0,   0, 1, 8'h00, 0, 0, 0};
    vt[1] = '{1, 1, 0, 1,   0, 1, 8'h00, 0, 0, 0};
    vt[2] = '{1, 0, 0, 0,   1, 1, 8'hAA, 1, 0, 0};
    vt[3] = '{1, 0, 1, 0,   1, 1, 8'hAA, 1, 0, 0};
    vt[4] = '{1, 1, 1, 2,   1, 1, 8'hAA, 0, 0, 0};
    vt[5] = '{1, 0, 1, 0,   1, 0, 8'hAA, 0, 0, 0};

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, junk, 1'b0);
    chk_en = 1'b1;

    // Reset state, alternating frame A, ones frame B captured into shadow.
    for (int i = 0; i < 6; i++) begin
      pre(vt[i].rn, vt[i].iv, pat_frame(vt[i].pat), vt[i].ordy);
      cmp($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].ev));
      cmp($sformatf("vec%0d_ready", i), 32'(in_ready),  32'(vt[i].er));
      cmp($sformatf("vec%0d_data", i),  32'(out_data),  32'(vt[i].ed));
      cmp($sformatf("vec%0d_sol", i),   32'(out_sol),   32'(vt[i].es));
      cmp($sformatf("vec%0d_eol", i),   32'(out_eol),   32'(vt[i].ee));
      cmp($sformatf("vec%0d_eof", i),   32'(out_eof),   32'(vt[i].ef));
      cmp($sformatf("vec%0d_cnt", i),   32'(frame_cnt), 32'd0);
      post();
    end

    // Rest of A (777 words) then B (780) with no bubble between them.
    drain(1'b0, n);
    cmp("b2b_cycles", 32'(n), 32'd1557);
    pre(1'b1, 1'b0, junk, 1'b1);
    cmp("b2b_cnt", 32'(frame_cnt), 32'd2);
    cmp("b2b_idle_ready", 32'(in_ready), 32'd1);
    cmp("b2b_idle_valid", 32'(out_valid), 32'd0);
    post();

    // Backpressure with a single lit pixel at row 3, col 9.
    wcnt = 0; nz_cnt = 0; nz_idx = -1; nz_val = '0;
    step(1'b1, 1'b1, pat_frame(3), 1'($urandom_range(0, 1)));
    drain(1'b1, n);
    cmp("bp_nz_count", 32'(nz_cnt), 32'd1);
    cmp("bp_nz_index", 32'(nz_idx), 32'd46);
    cmp("bp_nz_value", 32'(nz_val), 32'h02);

    // Same-cycle handoff at eof with shadow empty.
    step(1'b1, 1'b1, pat_frame(0), 1'b1);
    n = 0;
    while (!(fq.size() == 1 && pos == WPF - 1) && n < 2000) begin
      step(1'b1, 1'b0, junk, 1'b1); n++;
    end
    cur = rnd_frame();
    pre(1'b1, 1'b1, cur, 1'b1);
    cmp("handoff_ready", 32'(in_ready), 32'd1);
    cmp("handoff_eof", 32'(out_eof), 32'd1);
    post();
    pre(1'b1, 1'b0, junk, 1'b1);
    cmp("handoff_valid", 32'(out_valid), 32'd1);
    cmp("handoff_sol", 32'(out_sol), 32'd1);
    cmp("handoff_word0", 32'(out_data), 32'(cur[OW-1:0]));
    post();
    drain(1'b0, n);

    // Reset at word 400 while shadow is full.
    step(1'b1, 1'b1, rnd_frame(), 1'b1);
    step(1'b1, 1'b1, rnd_frame(), 1'b1);
    n = 0;
    while (pos != 400 && n < 2000) begin step(1'b1, 1'b0, junk, 1'b1); n++; end
    pre(1'b0, 1'b0, junk, 1'b1);
    cmp("rst_shadow_full", 32'(in_ready), 32'd0);
    post();
    pre(1'b1, 1'b0, junk, 1'b1);
    cmp("rst_valid", 32'(out_valid), 32'd0);
    cmp("rst_ready", 32'(in_ready), 32'd1);
    cmp("rst_cnt", 32'(frame_cnt), 32'd0);
    cmp("rst_data", 32'(out_data), 32'd0);
    post();
    step(1'b1, 1'b1, rnd_frame(), 1'b1);
    drain(1'b0, n);

    // Counter wrap over 5 back-to-back frames.
    step(1'b0, 1'b0, junk, 1'b1);
    k = 0; pushed = 0; pend = 0; cur = rnd_frame();
    for (int c = 0; c < 6000 && k < 5; c++) begin
      pre(1'b1, pushed < 5, cur, 1'b1);
      if (pend) begin cmp($sformatf("wrap_cnt%0d", k), 32'(frame_cnt), 32'(exp_wrap[k])); k++; pend = 0; end
      e0 = eof_seen;
      post();
      if (acc_in_last) begin pushed++; cur = rnd_frame(); end
      if (eof_seen != e0) pend = 1;
    end
    total++;
    if (k < 5) begin bad++; $display("FAIL wrap_timeout: got %0d frames want 5", k); end

    // Random traffic: sparse frames, random backpressure, rare resets.
    for (int c = 0; c < 4000; c++) begin
      step(($urandom_range(0, 1999) != 0), ($urandom_range(0, 3) == 0),
           (c % 64 == 0) ? rnd_frame() : junk, ($urandom_range(0, 3) != 0));
      if (c % 64 == 0) junk = rnd_frame();
    end
    drain(1'b0, n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
